pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-chunk adder; the successor to the team's combinational half/full adder cells.
- Splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, with carry registered between stages.
- Valid/ready handshake on both sides; full throughput of one add per cycle.
- Used as the arithmetic datapath element wherever wide adds must meet timing.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages, 1..WIDTH. CHUNK = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of the MSB (unsigned overflow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0, all data/carry registers 0. sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 in the first cycle after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid must not depend combinationally on out_ready.
  - sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
- Stage k (0..STAGES-1) registers:
  - valid bit v[k];
  - completed low sum bits [(k+1)*CHUNK-1:0];
  - carry out of chunk k;
  - unprocessed upper chunks of a and b.
- Stage 0 adds chunk 0 of a and b with cin. Stage k adds chunk k using stage k-1's registered carry.
- The last stage's registers drive sum, cout and ovf directly. out_valid = v[STAGES-1].
- ovf requires the carry into bit WIDTH-1. The last stage computes it internally, with the MSB adder split as needed.
- Advance rule (bubble-collapsing):
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - Stage k loads from stage k-1 (or from the inputs for k=0) when adv[k]. v[k] gets the upstream valid.
- in_ready = adv[0]. This is combinational from out_ready through the chain, and is permitted.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1. It is visible in the cycle following that edge, i.e. STAGES register stages, assuming no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall:
  - With out_ready=0, the pipeline fills. in_ready falls only once all STAGES valid bits are 1.
  - Bubbles are always squeezed out; no result is dropped or duplicated.
  - Order is preserved.
- Simultaneous events:
  - With a full pipeline and out_ready=1 in the same cycle as in_valid=1, the output transfer and the input acceptance both occur.
- Wrap-around: sum is modulo 2^WIDTH and cout captures bit WIDTH. Examples for WIDTH=8: 0xFF+0x00+cin=1 gives sum 0x00, cout 1; 0xFF+0xFF+1 gives sum 0xFF, cout 1.
- Reset mid-operation: all in-flight results are discarded immediately. out_valid drops asynchronously. No result from before reset emerges afterwards.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- X on a, b or cin while in_valid=0 must not propagate to valid bits.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1. Apply a=0xFF, b=0x01, cin=0 → two cycles later out_valid=1, sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
- Back-to-back stream, same config. Drive 16 random operand sets on consecutive cycles with out_ready=1 → 16 consecutive out_valid cycles. Results match a+b+cin in order. in_ready stays 1 throughout.
- Backpressure. Hold out_ready=0 while issuing 3 ops with STAGES=2 → in_ready=0 after 2 accepts. Output is held stable. Releasing out_ready drains both results in order, then accepts the third.
- Random in_valid/out_ready toggling at 50% for 1000 ops, WIDTH=16, STAGES=4 → scoreboard matches. No drops, no duplicates. cout and ovf are correct, including 0x8000+0x8000 (sum 0x0000, cout=1, ovf=1).
- Reset mid-operation. Accept 2 ops, assert reset for 1 cycle → out_valid=0 immediately and sum=0. The next op accepted after reset is the first one to appear.
- STAGES=1, WIDTH=4. a=0xF, b=0xF, cin=1 → one cycle later sum=0xF, cout=1, ovf=0.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-chunk adder: WIDTH-bit add split into STAGES chunks, one per stage,
// carry registered between stages, valid/ready on both sides with bubble collapsing.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] v_reg;
   logic [STAGES-1:0] c_reg;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  sum_reg [STAGES];
   logic [WIDTH-1:0]  a_reg   [STAGES];
   logic [WIDTH-1:0]  b_reg   [STAGES];
   logic              ovf_reg;

   // A stage may load when it is empty or when everything downstream of it moves.
   always_comb begin
      logic chain;
      adv   = '0;
      chain = !v_reg[STAGES-1] || out_ready;
      adv[STAGES-1] = chain;
      for (int k = STAGES - 2; k >= 0; k--) begin
         chain  = !v_reg[k] || chain;
         adv[k] = chain;
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic             up_valid;
         logic [WIDTH-1:0] up_a;
         logic [WIDTH-1:0] up_b;
         logic [WIDTH-1:0] up_sum;
         logic             up_c;
         logic [CHUNK:0]   chunk_add;
         logic [WIDTH-1:0] sum_next;

         if (gi == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_a     = a;
            assign up_b     = b;
            assign up_sum   = '0;
            assign up_c     = cin;
         end else begin : g_next
            assign up_valid = v_reg[gi-1];
            assign up_a     = a_reg[gi-1];
            assign up_b     = b_reg[gi-1];
            assign up_sum   = sum_reg[gi-1];
            assign up_c     = c_reg[gi-1];
         end

         assign chunk_add = {1'b0, up_a[gi*CHUNK +: CHUNK]}
                          + {1'b0, up_b[gi*CHUNK +: CHUNK]}
                          + {{CHUNK{1'b0}}, up_c};

         always_comb begin
            sum_next = up_sum;
            sum_next[gi*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
         end

         // Data only moves with a valid token, so idle X operands never reach the registers.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               v_reg[gi]   <= 1'b0;
               c_reg[gi]   <= 1'b0;
               sum_reg[gi] <= '0;
               a_reg[gi]   <= '0;
               b_reg[gi]   <= '0;
            end else if (adv[gi]) begin
               v_reg[gi] <= up_valid;
               if (up_valid) begin
                  c_reg[gi]   <= chunk_add[CHUNK];
                  sum_reg[gi] <= sum_next;
                  a_reg[gi]   <= up_a;
                  b_reg[gi]   <= up_b;
               end
            end
         end

         if (gi == STAGES - 1) begin : g_last
            logic msb_carry;
            // Carry into the MSB recovered from the MSB sum bit and its operand bits.
            assign msb_carry = sum_next[WIDTH-1] ^ up_a[WIDTH-1] ^ up_b[WIDTH-1];

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  ovf_reg <= 1'b0;
               end else if (adv[gi] && up_valid) begin
                  ovf_reg <= msb_carry ^ chunk_add[CHUNK];
               end
            end
         end
      end
   endgenerate

   assign in_ready  = adv[0];
   assign out_valid = v_reg[STAGES-1];
   assign sum       = sum_reg[STAGES-1];
   assign cout      = c_reg[STAGES-1];
   assign ovf       = ovf_reg;

endmodule
